// File: rtl/wb_uart_lite_pkg.sv
// Shared constants for wb_uart_lite: register map, bit positions, FSM states.
// UART_PARITY_EN widens the state encoding to add a PARITY state.
package wb_uart_lite_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_FRAME    = 4;
  localparam int ST_TXOVF    = 5;
  localparam int ST_PARITY   = 6;

  localparam int CTRL_RX_IE  = 0;
  localparam int CTRL_TX_IE  = 1;
  localparam int CTRL_ERR_IE = 2;

  localparam logic [15:0] DIV_MIN = 16'd2;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } uart_st_e;
  localparam uart_st_e AFTER_DATA = S_PARITY;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } uart_st_e;
  localparam uart_st_e AFTER_DATA = S_STOP;
`endif

  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous byte FIFO for the UART transmit path.
// A push into a full FIFO is accepted when a pop frees a slot that cycle.
module uart_tx_fifo #(
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(TX_DEPTH);

  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone UART: TX FIFO + serialiser, synchronised RX, divider, level irq.
// Build option UART_PARITY_EN adds an even-parity bit on both paths.
module wb_uart_lite
  import wb_uart_lite_pkg::*;
#(
  parameter int          TX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd434,
  parameter int          DW        = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [DW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_stall_o,
  output logic          uart_tx_o,
  input  logic          uart_rx_i,
  output logic          irq_o
);

  logic          req, is_err, wr, rd;
  logic [1:0]    ridx;
  logic          wr_data, wr_stat, wr_div, wr_ctrl, rd_data;
  logic [DW-1:0] rdata;
  logic [6:0]    stat;
  logic [15:0]   div_q, div_m1, half_m1;
  logic [2:0]    ctrl_q;
  logic [7:0]    rx_byte;
  logic          rx_valid, ovr, fe, pe, txovf;
  logic          fifo_full, fifo_empty, tx_empty;
  logic [7:0]    fifo_dout;
  logic          unused_bits;

  uart_st_e    tx_st, tx_nx;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic        tx_pop, tx_tick;

  uart_st_e    rx_st, rx_nx;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_d, rx_tick, rx_drop;
  logic        rx_load, rx_set_fe, rx_set_ovr, rx_set_pe;

  assign wb_stall_o  = 1'b0;
  assign unused_bits = ^{wb_adr_i[DW-1:4],
                         wb_dat_i[DW-1:16],
                         wb_sel_i[3:2]};

  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign is_err = |wb_adr_i[1:0];
  assign ridx   = wb_adr_i[3:2];
  assign wr     = req & ~is_err & wb_we_i;
  assign rd     = req & ~is_err & ~wb_we_i;

  assign div_m1   = eff_div(div_q) - 16'd1;
  assign half_m1  = (eff_div(div_q) >> 1) - 16'd1;
  assign tx_empty = fifo_empty & (tx_st == S_IDLE);

  always_comb begin
    stat              = '0;
    stat[ST_TX_EMPTY] = tx_empty;
    stat[ST_TX_FULL]  = fifo_full;
    stat[ST_RX_VALID] = rx_valid;
    stat[ST_OVERRUN]  = ovr;
    stat[ST_FRAME]    = fe;
    stat[ST_TXOVF]    = txovf;
    stat[ST_PARITY]   = pe;
  end

  always_comb begin
    wr_data = 1'b0;
    wr_stat = 1'b0;
    wr_div  = 1'b0;
    wr_ctrl = 1'b0;
    rd_data = 1'b0;
    rdata   = '0;
    unique case (1'b1)
      (ridx == REG_DATA): begin
        wr_data    = wr & wb_sel_i[0];
        rd_data    = rd;
        rdata[8:0] = {rx_valid, rx_byte};
      end
      (ridx == REG_STAT): begin
        wr_stat    = wr & wb_sel_i[0];
        rdata[6:0] = stat;
      end
      (ridx == REG_DIV): begin
        wr_div      = wr;
        rdata[15:0] = div_q;
      end
      (ridx == REG_CTRL): begin
        wr_ctrl    = wr & wb_sel_i[0];
        rdata[2:0] = ctrl_q;
      end
      default: ;
    endcase
  end

  uart_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (wr_data),
    .pop   (tx_pop),
    .din   (wb_dat_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      div_q    <= DIV_RESET;
      ctrl_q   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      fe       <= 1'b0;
      pe       <= 1'b0;
      txovf    <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= req & ~is_err;
      wb_err_o <= req & is_err;
      if (rd) wb_dat_o <= rdata;
      if (wr_div && wb_sel_i[0]) div_q[7:0]  <= wb_dat_i[7:0];
      if (wr_div && wb_sel_i[1]) div_q[15:8] <= wb_dat_i[15:8];
      if (wr_ctrl) ctrl_q <= wb_dat_i[2:0];
      if (wr_stat) begin
        if (wb_dat_i[ST_OVERRUN]) ovr   <= 1'b0;
        if (wb_dat_i[ST_FRAME])   fe    <= 1'b0;
        if (wb_dat_i[ST_TXOVF])   txovf <= 1'b0;
        if (wb_dat_i[ST_PARITY])  pe    <= 1'b0;
      end
      // hardware events beat a same-cycle W1C
      if (rx_set_ovr) ovr <= 1'b1;
      if (rx_set_fe)  fe  <= 1'b1;
      if (rx_set_pe)  pe  <= 1'b1;
      if (wr_data && fifo_full && !tx_pop) txovf <= 1'b1;
      if (rx_load) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      irq_o <= (ctrl_q[CTRL_RX_IE] & rx_valid) |
               (ctrl_q[CTRL_TX_IE] & tx_empty) |
               (ctrl_q[CTRL_ERR_IE] & (ovr | fe | pe));
    end
  end

  assign tx_tick = (tx_cnt == 16'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_idx <= '0;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_n;
      tx_sh  <= tx_sh_n;
      tx_idx <= tx_idx_n;
    end
  end

  always_comb begin
    tx_nx    = tx_st;
    tx_cnt_n = tx_cnt;
    tx_sh_n  = tx_sh;
    tx_idx_n = tx_idx;
    tx_pop   = 1'b0;
    case (tx_st)
      S_IDLE: begin
        if (!fifo_empty) begin
          tx_pop   = 1'b1;
          tx_sh_n  = fifo_dout;
          tx_cnt_n = div_m1;
          tx_nx    = S_START;
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_nx    = S_DATA;
          tx_cnt_n = div_m1;
          tx_idx_n = '0;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          tx_cnt_n = div_m1;
          tx_sh_n  = tx_sh >> 1;
          tx_idx_n = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_nx = AFTER_DATA;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tx_tick) begin
          tx_nx    = S_STOP;
          tx_cnt_n = div_m1;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (tx_tick) begin
          // chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            tx_pop   = 1'b1;
            tx_sh_n  = fifo_dout;
            tx_cnt_n = div_m1;
            tx_nx    = S_START;
          end else begin
            tx_nx = S_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_nx = S_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic tx_par;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)    tx_par <= 1'b0;
    else if (tx_pop) tx_par <= ^fifo_dout;
  end
`endif

  always_comb begin
    uart_tx_o = 1'b1;
    case (tx_st)
      S_START:  uart_tx_o = 1'b0;
      S_DATA:   uart_tx_o = tx_sh[0];
`ifdef UART_PARITY_EN
      S_PARITY: uart_tx_o = tx_par;
`endif
      default:  uart_tx_o = 1'b1;
    endcase
  end

  assign rx_s    = rx_sync[1];
  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_sync <= 2'b11;
      rx_d    <= 1'b1;
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_idx  <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx_i};
      rx_d    <= rx_s;
      rx_st   <= rx_nx;
      rx_cnt  <= rx_cnt_n;
      rx_sh   <= rx_sh_n;
      rx_idx  <= rx_idx_n;
    end
  end

`ifdef UART_PARITY_EN
  logic rx_perr, rx_pbad;

  assign rx_perr = rx_s ^ (^rx_sh);
  assign rx_drop = rx_pbad;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      rx_pbad <= 1'b0;
    else if (rx_st == S_PARITY && rx_tick)
      rx_pbad <= rx_perr;
  end
`else
  assign rx_drop = 1'b0;
`endif

  always_comb begin
    rx_nx      = rx_st;
    rx_cnt_n   = rx_cnt;
    rx_sh_n    = rx_sh;
    rx_idx_n   = rx_idx;
    rx_load    = 1'b0;
    rx_set_fe  = 1'b0;
    rx_set_ovr = 1'b0;
    rx_set_pe  = 1'b0;
    case (rx_st)
      S_IDLE: begin
        if (rx_d && !rx_s) begin
          rx_nx    = S_START;
          rx_cnt_n = half_m1;
        end
      end
      S_START: begin
        if (rx_tick) begin
          if (rx_s) begin
            rx_nx = S_IDLE;
          end else begin
            rx_nx    = S_DATA;
            rx_cnt_n = div_m1;
            rx_idx_n = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_tick) begin
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_idx_n = rx_idx + 3'd1;
          rx_cnt_n = div_m1;
          if (rx_idx == 3'd7) rx_nx = AFTER_DATA;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (rx_tick) begin
          rx_set_pe = rx_perr;
          rx_nx     = S_STOP;
          rx_cnt_n  = div_m1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (rx_tick) begin
          rx_nx = S_IDLE;
          if (!rx_s)         rx_set_fe  = 1'b1;
          else if (rx_drop)  rx_set_fe  = 1'b0;
          else if (rx_valid) rx_set_ovr = 1'b1;
          else               rx_load    = 1'b1;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_nx = S_IDLE;
    endcase
  end

endmodule
